// File: rtl/logicap_pkg.sv
// Shared definitions for the logic-capture chain: ring-buffer state encoding and a clog2 helper.
package logicap_pkg;

  localparam logic [1:0] RB_IDLE  = 2'd0;
  localparam logic [1:0] RB_FILL  = 2'd1;
  localparam logic [1:0] RB_SETUP = 2'd2;
  localparam logic [1:0] RB_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = RB_IDLE,
    ST_FILL  = RB_FILL,
    ST_SETUP = RB_SETUP,
    ST_DRAIN = RB_DRAIN
  } rb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one read port with a registered output.
module sample_ram #(
  parameter int size    = 32,
  parameter int saddr_w = 10
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [saddr_w-1:0] wr_addr_i,
  input  logic [size-1:0]    wr_data_i,
  input  logic               rd_en_i,
  input  logic [saddr_w-1:0] rd_addr_i,
  output logic [size-1:0]    rd_data_o
);

  logic [size-1:0] mem_q [2**saddr_w];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/sample_ring_buffer.sv
// Circular capture buffer that replays the last buffer_size samples oldest-first.
// Optional SAMPLE_RING_LEVEL_EN adds fill_level and overflowed outputs.
module sample_ring_buffer
  import logicap_pkg::*;
#(
  parameter int size    = 32,
  parameter int saddr_w = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               capture_done,
  input  logic [saddr_w-1:0] buffer_size,
  input  logic [size-1:0]    s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [size-1:0]    m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic               drain_done
`ifdef SAMPLE_RING_LEVEL_EN
  ,
  output logic [saddr_w:0]   fill_level,
  output logic               overflowed
`endif
);

  localparam int DEPTH = 2 ** saddr_w;
  localparam int PW    = saddr_w + 1;
  typedef logic [PW-1:0] ptr_t;

  rb_state_e             state_q, state_d;
  ptr_t                  len_q, len_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic                  wrapped_q, wrapped_d;
  ptr_t                  to_issue_q, to_issue_d;
  ptr_t                  out_left_q, out_left_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [size-1:0]       skid0_q, skid0_d;
  logic [size-1:0]       skid1_q, skid1_d;
  logic [SKID_CNT_W-1:0] skid_cnt_q, skid_cnt_d;
  logic                  drain_done_q, drain_done_d;

  logic                  wr_fire, wr_wrap, pop, kill, start_go, credit;
  logic                  rd_en;
  logic [saddr_w-1:0]    rd_addr;
  logic [size-1:0]       rd_data;
  ptr_t                  setup_first, setup_count;
  logic [SKID_CNT_W:0]   occ;

  function automatic ptr_t ptr_inc(input ptr_t p, input ptr_t len);
    return (p == len - 1'b1) ? '0 : p + 1'b1;
  endfunction

  assign start_go    = (state_q == ST_IDLE) && start && !abort;
  assign kill        = abort || (start && (state_q != ST_IDLE));
  assign wr_fire     = (state_q == ST_FILL) && s_tvalid;
  assign wr_wrap     = wr_fire && (wr_ptr_q == len_q - 1'b1);
  assign pop         = m_tvalid && m_tready;
  assign setup_first = wrapped_q ? wr_ptr_q : '0;
  assign setup_count = wrapped_q ? len_q : wr_ptr_q;
  // A read may be launched when the skid plus the in-flight read leave a free slot.
  assign occ         = {1'b0, skid_cnt_q} + {{SKID_CNT_W{1'b0}}, rd_pend_q};
  assign credit      = (occ < (SKID_CNT_W + 1)'(SKID_DEPTH)) || pop;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wrapped_d    = wrapped_q;
    to_issue_d   = to_issue_q;
    out_left_d   = out_left_q;
    drain_done_d = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = rd_ptr_q[saddr_w-1:0];

    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d   = ST_FILL;
          len_d     = (buffer_size == '0) ? PW'(DEPTH) : {1'b0, buffer_size};
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          wrapped_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (wr_fire) begin
          wr_ptr_d = ptr_inc(wr_ptr_q, len_q);
          if (wr_wrap) wrapped_d = 1'b1;
        end
        if (capture_done) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (setup_count == '0) begin
          state_d = ST_IDLE;
        end else begin
          rd_en      = 1'b1;
          rd_addr    = setup_first[saddr_w-1:0];
          rd_ptr_d   = ptr_inc(setup_first, len_q);
          to_issue_d = setup_count - 1'b1;
          out_left_d = setup_count;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((to_issue_q != '0) && credit) begin
          rd_en      = 1'b1;
          rd_ptr_d   = ptr_inc(rd_ptr_q, len_q);
          to_issue_d = to_issue_q - 1'b1;
        end
        if (pop) begin
          out_left_d = out_left_q - 1'b1;
          if (out_left_q == PW'(1)) begin
            state_d      = ST_IDLE;
            drain_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d      = ST_IDLE;
      rd_en        = 1'b0;
      drain_done_d = 1'b0;
    end
  end

  // Two-entry output skid fed by the registered RAM read.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    rd_pend_d  = rd_en;
    case ({rd_pend_q, pop})
      2'b10: begin
        if (skid_cnt_q == '0) skid0_d = rd_data;
        else                  skid1_d = rd_data;
        skid_cnt_d = skid_cnt_q + 1'b1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 1'b1;
      end
      2'b11: begin
        if (skid_cnt_q == SKID_CNT_W'(1)) begin
          skid0_d = rd_data;
        end else begin
          skid0_d = skid1_q;
          skid1_d = rd_data;
        end
      end
      default: ;
    endcase
    if (kill) begin
      skid_cnt_d = '0;
      rd_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wrapped_q    <= 1'b0;
      to_issue_q   <= '0;
      out_left_q   <= '0;
      rd_pend_q    <= 1'b0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wrapped_q    <= wrapped_d;
      to_issue_q   <= to_issue_d;
      out_left_q   <= out_left_d;
      rd_pend_q    <= rd_pend_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_cnt_q   <= skid_cnt_d;
      drain_done_q <= drain_done_d;
    end
  end

  sample_ram #(
    .size   (size),
    .saddr_w(saddr_w)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (wr_fire),
    .wr_addr_i(wr_ptr_q[saddr_w-1:0]),
    .wr_data_i(s_tdata),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign s_tready   = (state_q == ST_FILL);
  assign busy       = (state_q != ST_IDLE);
  assign m_tvalid   = (skid_cnt_q != '0);
  assign m_tdata    = skid0_q;
  assign m_tlast    = m_tvalid && (out_left_q == PW'(1));
  assign drain_done = drain_done_q;

`ifdef SAMPLE_RING_LEVEL_EN
  logic [saddr_w:0] level_q, level_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    if (start_go) begin
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_fire && (level_q != len_q)) level_d = level_q + 1'b1;
      if (wr_wrap)                       ovf_d   = 1'b1;
      if (pop && (level_q != '0))        level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fill_level = level_q;
  assign overflowed = ovf_q;
`endif

endmodule
